// File: rtl/sd_wfifo_burst_feeder.sv
// sd_wfifo_burst_feeder
//   Sits between the SD_W_MUX output and the push side of the SDRAM write
//   FIFO. Upstream words are gathered into a local burst buffer and then
//   released to the FIFO as one contiguous push sequence, so the SDRAM side
//   always sees whole bursts. FIFO-full backpressure stalls the drain without
//   dropping, duplicating or reordering words.
//
// Ports
//   sys_clk, sys_rst_n  clock (rising edge) and async active-low reset
//   in_valid, in_data   upstream word; accepted when in_valid && in_ready
//   in_ready            high whenever the block is not draining
//   flush               close the current partial burst and drain it
//   fifo_full           FIFO push-side full; pauses the drain
//   fifo_push_req_n     active-low push strobe to the FIFO
//   fifo_data           word presented to the FIFO (buf[rd_ptr])
//   burst_done          one-cycle pulse after the last word of a burst
//   burst_words         word count of the last completed burst (held)
//   busy                state != IDLE
//
// Optional feature macro: SD_FEEDER_TIMEOUT_EN
//   When defined, a partial burst that sees TIMEOUT_CYCLES consecutive idle
//   cycles in COLLECT is drained as if flush had been asserted. When not
//   defined no idle counter exists and partial bursts leave only on flush.

module sd_wfifo_burst_feeder #(
  parameter int DATA_WIDTH     = 32,
  parameter int BURST_LEN      = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst_n,
  input  logic                         in_valid,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         in_ready,
  input  logic                         flush,
  input  logic                         fifo_full,
  output logic                         fifo_push_req_n,
  output logic [DATA_WIDTH-1:0]        fifo_data,
  output logic                         burst_done,
  output logic [$clog2(BURST_LEN):0]   burst_words,
  output logic                         busy
);

  // Counter width holds the value BURST_LEN itself, so no wrap in a burst.
  localparam int CW = $clog2(BURST_LEN) + 1;
  // Buffer address width; kept at least one bit so BURST_LEN==1 still has
  // a legal index slice.
  localparam int AW    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int DEPTH = 1 << AW;

  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] LAST_CNT = CW'(BURST_LEN);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           wr_cnt, wr_cnt_nxt;
  logic [CW-1:0]           rd_ptr, rd_ptr_nxt;
  logic [CW-1:0]           wr_cnt_inc, rd_ptr_inc;
  logic                    done_nxt;
  logic [CW-1:0]           words_nxt;
  logic                    wr_en;
  logic                    accept;
  logic                    timeout;
  logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];

  assign accept     = in_valid && in_ready;
  assign wr_cnt_inc = wr_cnt + ONE;
  assign rd_ptr_inc = rd_ptr + ONE;

  // Handshake and push strobe are combinational from state so the first
  // push lands in the cycle right after the edge that enters DRAIN.
  assign in_ready        = (state != DRAIN);
  assign fifo_push_req_n = !((state == DRAIN) && !fifo_full);
  assign fifo_data       = mem[rd_ptr[AW-1:0]];
  assign busy            = (state != IDLE);

`ifdef SD_FEEDER_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  logic [IW-1:0] idle_cnt;

  // Counts consecutive no-accept cycles while collecting a partial burst.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      idle_cnt <= '0;
    end else if ((state == COLLECT) && !accept && !timeout) begin
      idle_cnt <= idle_cnt + IW'(1);
    end else begin
      idle_cnt <= '0;
    end
  end

  // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle.
  assign timeout = (state == COLLECT) && !accept &&
                   (idle_cnt == IW'(TIMEOUT_CYCLES - 1));
`else
  // No idle timer; the expression is constant false for any legal value.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  // Burst buffer write port; contents need no reset since the pointers do.
  always_ff @(posedge sys_clk) begin
    if (wr_en) begin
      mem[wr_cnt[AW-1:0]] <= in_data;
    end
  end

  // State, pointer and status registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      wr_cnt      <= '0;
      rd_ptr      <= '0;
      burst_done  <= 1'b0;
      burst_words <= '0;
    end else begin
      state       <= state_nxt;
      wr_cnt      <= wr_cnt_nxt;
      rd_ptr      <= rd_ptr_nxt;
      burst_done  <= done_nxt;
      burst_words <= words_nxt;
    end
  end

  // Next-state logic: collect, close on full/flush/timeout, then drain.
  always_comb begin
    state_nxt  = state;
    wr_cnt_nxt = wr_cnt;
    rd_ptr_nxt = rd_ptr;
    done_nxt   = 1'b0;
    words_nxt  = burst_words;
    wr_en      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          wr_en      = 1'b1;
          wr_cnt_nxt = ONE;
          if (BURST_LEN == 1) begin
            state_nxt = DRAIN;
          end else begin
            state_nxt = COLLECT;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      COLLECT: begin
        if (accept) begin
          wr_en      = 1'b1;
          wr_cnt_nxt = wr_cnt_inc;
        end else begin
          wr_cnt_nxt = wr_cnt;
        end
        // A flush that coincides with an accept still includes that word,
        // because the drain length is taken from the updated wr_cnt.
        if ((accept && (wr_cnt_inc == LAST_CNT)) || flush || timeout) begin
          state_nxt = DRAIN;
        end else begin
          state_nxt = COLLECT;
        end
      end
      DRAIN: begin
        if (!fifo_full) begin
          if (rd_ptr_inc == wr_cnt) begin
            state_nxt  = IDLE;
            wr_cnt_nxt = '0;
            rd_ptr_nxt = '0;
            done_nxt   = 1'b1;
            words_nxt  = wr_cnt;
          end else begin
            state_nxt  = DRAIN;
            rd_ptr_nxt = rd_ptr_inc;
          end
        end else begin
          state_nxt  = DRAIN;
          rd_ptr_nxt = rd_ptr;
        end
      end
      default: begin
        state_nxt  = IDLE;
        wr_cnt_nxt = '0;
        rd_ptr_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_sd_wfifo_burst_feeder.sv
`timescale 1ns/1ps
module tb_sd_wfifo_burst_feeder;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        in_valid  = 1'b0;
  logic [31:0] in_data   = 32'h0;
  logic        flush     = 1'b0;
  logic        fifo_full = 1'b0;
  logic        in_ready;
  logic        fifo_push_req_n;
  logic [31:0] fifo_data;
  logic        burst_done;
  logic [3:0]  burst_words;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] cap [$];
  int          held_bad;
  int          done_cnt;
  int          done_cyc;
  logic [3:0]  done_words;
  logic        ready_first;

  always #5 sys_clk = ~sys_clk;

  sd_wfifo_burst_feeder #(
    .DATA_WIDTH(32), .BURST_LEN(8), .TIMEOUT_CYCLES(16)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .flush(flush), .fifo_full(fifo_full),
    .fifo_push_req_n(fifo_push_req_n), .fifo_data(fifo_data),
    .burst_done(burst_done), .burst_words(burst_words), .busy(busy)
  );

  // Presents n consecutive words base, base+1, ...; optional flush on the last.
  task automatic send(input logic [31:0] base, input int n, input bit flush_last);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = base + 32'(i);
      flush    = flush_last && (i == n - 1);
      @(posedge sys_clk); #1;
    end
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  // Runs a fixed number of cycles, recording pushes and burst_done pulses.
  task automatic drain(input int budget, input int full_from, input int full_cnt,
                       input logic [31:0] hold_val);
    cap.delete();
    held_bad    = 0;
    done_cnt    = 0;
    done_cyc    = -1;
    done_words  = 4'h0;
    ready_first = 1'bx;
    for (int c = 0; c < budget; c++) begin
      fifo_full = (c >= full_from) && (c < full_from + full_cnt);
      @(negedge sys_clk);
      if (c == 0) ready_first = in_ready;
      if (fifo_full && (fifo_push_req_n !== 1'b1 || fifo_data !== hold_val)) held_bad++;
      if (fifo_push_req_n === 1'b0) cap.push_back(fifo_data);
      if (burst_done === 1'b1) begin
        done_cnt++;
        done_cyc   = c;
        done_words = burst_words;
      end
      @(posedge sys_clk); #1;
    end
    fifo_full = 1'b0;
  endtask

  task automatic test_reset;
    sys_rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    n_cmp++; if (fifo_push_req_n !== 1'b1) begin n_bad++; $display("FAIL rst_push_n: got %b want 1", fifo_push_req_n); end
    n_cmp++; if (burst_done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", burst_done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", in_ready); end
    n_cmp++; if (burst_words !== 4'd0) begin n_bad++; $display("FAIL rst_words: got %0d want 0", burst_words); end
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
  endtask

  task automatic test_full_burst;
    send(32'h1, 8, 1'b0);
    drain(12, 0, 0, 32'h0);
    n_cmp++; if (ready_first !== 1'b0) begin n_bad++; $display("FAIL t2_ready: got %b want 0", ready_first); end
    n_cmp++; if (cap.size() != 8) begin n_bad++; $display("FAIL t2_count: got %0d want 8", cap.size()); end
    for (int i = 0; i < 8 && i < cap.size(); i++) begin
      n_cmp++; if (cap[i] !== 32'(i + 1)) begin n_bad++; $display("FAIL t2_data[%0d]: got %h want %h", i, cap[i], 32'(i + 1)); end
    end
    n_cmp++; if (done_cnt != 1 || done_cyc != 8) begin n_bad++; $display("FAIL t2_done: got %0d pulses at %0d want 1 at 8", done_cnt, done_cyc); end
    n_cmp++; if (done_words !== 4'd8) begin n_bad++; $display("FAIL t2_words: got %0d want 8", done_words); end
    n_cmp++; if (busy !== 1'b0 || burst_words !== 4'd8) begin n_bad++; $display("FAIL t2_after: busy %b words %0d want 0/8", busy, burst_words); end
  endtask

  task automatic test_backpressure;
    send(32'h1, 8, 1'b0);
    drain(16, 2, 4, 32'h3);
    n_cmp++; if (held_bad != 0) begin n_bad++; $display("FAIL t3_hold: got %0d bad stall cycles want 0", held_bad); end
    n_cmp++; if (cap.size() != 8) begin n_bad++; $display("FAIL t3_count: got %0d want 8", cap.size()); end
    for (int i = 0; i < 8 && i < cap.size(); i++) begin
      n_cmp++; if (cap[i] !== 32'(i + 1)) begin n_bad++; $display("FAIL t3_data[%0d]: got %h want %h", i, cap[i], 32'(i + 1)); end
    end
    n_cmp++; if (done_cnt != 1 || done_cyc != 12) begin n_bad++; $display("FAIL t3_done: got %0d pulses at %0d want 1 at 12", done_cnt, done_cyc); end
  endtask

  task automatic test_flush;
    send(32'hA, 3, 1'b0);
    flush = 1'b1;
    @(posedge sys_clk); #1;
    flush = 1'b0;
    drain(8, 0, 0, 32'h0);
    n_cmp++; if (cap.size() != 3) begin n_bad++; $display("FAIL t4_count: got %0d want 3", cap.size()); end
    for (int i = 0; i < 3 && i < cap.size(); i++) begin
      n_cmp++; if (cap[i] !== 32'hA + 32'(i)) begin n_bad++; $display("FAIL t4_data[%0d]: got %h want %h", i, cap[i], 32'hA + 32'(i)); end
    end
    n_cmp++; if (done_cnt != 1 || done_words !== 4'd3) begin n_bad++; $display("FAIL t4_words: got %0d pulses words %0d want 1/3", done_cnt, done_words); end
    // flush while idle must do nothing
    flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      n_cmp++; if (busy !== 1'b0 || fifo_push_req_n !== 1'b1) begin n_bad++; $display("FAIL t4_idle_flush: busy %b push_n %b want 0/1", busy, fifo_push_req_n); end
      @(posedge sys_clk); #1;
    end
    flush = 1'b0;
    // flush together with the 5th word
    send(32'h40, 5, 1'b1);
    drain(10, 0, 0, 32'h0);
    n_cmp++; if (cap.size() != 5) begin n_bad++; $display("FAIL t4_flush5_count: got %0d want 5", cap.size()); end
    for (int i = 0; i < 5 && i < cap.size(); i++) begin
      n_cmp++; if (cap[i] !== 32'h40 + 32'(i)) begin n_bad++; $display("FAIL t4_flush5_data[%0d]: got %h want %h", i, cap[i], 32'h40 + 32'(i)); end
    end
    n_cmp++; if (done_words !== 4'd5) begin n_bad++; $display("FAIL t4_flush5_words: got %0d want 5", done_words); end
  endtask

  task automatic test_reset_mid_drain;
    send(32'h10, 8, 1'b0);
    drain(4, 0, 0, 32'h0);
    n_cmp++; if (cap.size() != 4) begin n_bad++; $display("FAIL t5_pre: got %0d pushes want 4", cap.size()); end
    sys_rst_n = 1'b0;
    #1;
    n_cmp++; if (fifo_push_req_n !== 1'b1) begin n_bad++; $display("FAIL t5_push_n: got %b want 1", fifo_push_req_n); end
    n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL t5_state: busy %b ready %b want 0/1", busy, in_ready); end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    send(32'h20, 8, 1'b0);
    drain(12, 0, 0, 32'h0);
    n_cmp++; if (cap.size() != 8) begin n_bad++; $display("FAIL t5_count: got %0d want 8", cap.size()); end
    for (int i = 0; i < 8 && i < cap.size(); i++) begin
      n_cmp++; if (cap[i] !== 32'h20 + 32'(i)) begin n_bad++; $display("FAIL t5_data[%0d]: got %h want %h", i, cap[i], 32'h20 + 32'(i)); end
    end
  endtask

  task automatic test_timeout;
    send(32'h50, 2, 1'b0);
`ifdef SD_FEEDER_TIMEOUT_EN
    drain(24, 0, 0, 32'h0);
    n_cmp++; if (cap.size() != 2) begin n_bad++; $display("FAIL t6_count: got %0d want 2", cap.size()); end
    n_cmp++; if (done_words !== 4'd2 || done_cyc != 18) begin n_bad++; $display("FAIL t6_done: words %0d at %0d want 2 at 18", done_words, done_cyc); end
`else
    drain(100, 0, 0, 32'h0);
    n_cmp++; if (cap.size() != 0) begin n_bad++; $display("FAIL t6_nopush: got %0d pushes want 0", cap.size()); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL t6_busy: got %b want 1", busy); end
    flush = 1'b1;
    @(posedge sys_clk); #1;
    flush = 1'b0;
    drain(6, 0, 0, 32'h0);
    n_cmp++; if (cap.size() != 2) begin n_bad++; $display("FAIL t6_flushed: got %0d pushes want 2", cap.size()); end
`endif
    for (int i = 0; i < 2 && i < cap.size(); i++) begin
      n_cmp++; if (cap[i] !== 32'h50 + 32'(i)) begin n_bad++; $display("FAIL t6_data[%0d]: got %h want %h", i, cap[i], 32'h50 + 32'(i)); end
    end
  endtask

  initial begin
    test_reset();
    test_full_burst();
    test_backpressure();
    test_flush();
    test_reset_mid_drain();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
